// File: rtl/exec_ctrl_unit_pkg.sv
// Shared encodings for the exec_ctrl_unit decode/execute slice: opcodes, functs,
// ALU-op classes, ALU operation codes and the decoded control bundle.
package exec_ctrl_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       regdest;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // Unknown functions and the reserved aluop class both fall back to add.
    function automatic logic [3:0] alu_ctrl(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  op = ALU_ADD;
                    FN_SUB:  op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_SLT:  op = ALU_SLT;
                    FN_NOR:  op = ALU_NOR;
                    default: op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_ctrl_unit_alu.sv
// Purely combinational ALU with zero flag; undefined operation codes yield 0.
module exec_alu
    import exec_ctrl_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero
);

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign sa = $signed(data_a);
    assign sb = $signed(data_b);

    always_comb begin
        aluresult = '0;
        case (operation)
            ALU_AND: aluresult = data_a & data_b;
            ALU_OR:  aluresult = data_a | data_b;
            ALU_ADD: aluresult = data_a + data_b;
            ALU_SUB: aluresult = data_a - data_b;
            ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, (sa < sb)};
            ALU_NOR: aluresult = ~(data_a | data_b);
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

endmodule

// File: rtl/exec_ctrl_unit.sv
// Single-cycle MIPS-subset main decode, ALU control and ALU, with a sticky HALT
// flag that masks every side-effecting control output once set.
module exec_ctrl_unit
    import exec_ctrl_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             regdest,
    output logic             jump,
    output logic             branch,
    output logic             memread,
    output logic             memtoreg,
    output logic             memwrite,
    output logic             alusrc,
    output logic             regwrite,
    output logic [1:0]       aluop,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero,
    output logic             halted
);

    ctrl_t dec;

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.regdest  = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.aluop    = ALUOP_ADD;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.aluop  = ALUOP_SUB;
            end
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_ADD;
            end
            OP_J: begin
                dec.jump = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    // Halt capture: reset wins over a halt opcode on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (opcode == OP_HALT) begin
            halted <= 1'b1;
        end
    end

    // Only state-changing controls are masked; datapath selects keep decoding.
    assign regdest   = dec.regdest;
    assign alusrc    = dec.alusrc;
    assign memtoreg  = dec.memtoreg;
    assign aluop     = dec.aluop;
    assign regwrite  = dec.regwrite & ~halted;
    assign memread   = dec.memread  & ~halted;
    assign memwrite  = dec.memwrite & ~halted;
    assign branch    = dec.branch   & ~halted;
    assign jump      = dec.jump     & ~halted;

    assign operation = alu_ctrl(dec.aluop, funct);

    exec_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .operation(operation),
        .data_a   (data_a),
        .data_b   (data_b),
        .aluresult(aluresult),
        .zero     (zero)
    );

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed plus randomized bench for exec_ctrl_unit against a table-driven reference model.
module tb_exec_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        regdest, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop;
    logic [3:0]  operation;
    logic [31:0] aluresult;
    logic        zero;
    logic        halted;

    int total = 0;
    int bad   = 0;
    bit mh    = 1'b0;

    always #5 clk = ~clk;

    exec_ctrl_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .data_a(data_a), .data_b(data_b),
        .regdest(regdest), .jump(jump), .branch(branch), .memread(memread),
        .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
        .aluop(aluop), .operation(operation), .aluresult(aluresult), .zero(zero),
        .halted(halted)
    );

    // Row order: RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp[1:0]
    function automatic logic [9:0] exp_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 10'b1_0_0_1_0_0_0_0_10;
            6'b100011: return 10'b0_1_1_1_1_0_0_0_00;
            6'b101011: return 10'b0_1_0_0_0_1_0_0_00;
            6'b000100: return 10'b0_0_0_0_0_0_1_0_01;
            6'b001000: return 10'b0_1_0_1_0_0_0_0_00;
            6'b000010: return 10'b0_0_0_0_0_0_0_1_00;
            default:   return 10'b0;
        endcase
    endfunction

    function automatic logic [3:0] exp_op(input logic [1:0] ao, input logic [5:0] fn);
        if (ao == 2'b01) return 4'b0110;
        if (ao != 2'b10) return 4'b0010;
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [31:0] exp_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every output against the model for the inputs currently applied.
    task automatic check_model();
        logic [9:0]  c;
        logic [3:0]  op;
        logic [31:0] r;
        c = exp_ctrl(opcode);
        if (mh) c = c & 10'b1_1_1_0_0_0_0_0_11;
        op = exp_op(c[1:0], funct);
        r  = exp_alu(op, data_a, data_b);
        chk("ctrl", {22'd0, regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, aluop},
            {22'd0, c});
        chk("operation", {28'd0, operation}, {28'd0, op});
        chk("aluresult", aluresult, r);
        chk("zero", {31'd0, zero}, {31'd0, (r == 32'd0)});
        chk("halted", {31'd0, halted}, {31'd0, mh});
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        opcode = op; funct = fn; data_a = a; data_b = b; reset = rst;
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) mh = 1'b0;
        else if (opcode == 6'b111111) mh = 1'b1;
        #1;
    endtask

    logic [5:0] op_list [8];
    logic [5:0] fn_list [6];

    initial begin
        op_list = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b010101};
        fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

        reset = 1'b1; opcode = 6'b0; funct = 6'b0; data_a = 32'd0; data_b = 32'd0;
        @(posedge clk); #1;
        mh = 1'b0;

        // Reset state
        drive(6'b000000, 6'b100000, 32'd0, 32'd0, 1'b1);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        tick();

        // Decode sweep (halt opcode excluded here so it does not latch)
        for (int i = 0; i < 8; i++) begin
            if (op_list[i] != 6'b111111) begin
                drive(op_list[i], 6'b100000, 32'd3, 32'd4, 1'b0);
                tick();
            end
        end
        drive(6'b111111, 6'b100000, 32'd3, 32'd4, 1'b1);
        chk("halt_row_regwrite", {31'd0, regwrite}, 32'd0);
        tick();

        drive(6'b000000, 6'b100010, 32'd5, 32'd7, 1'b0);
        chk("sub_op", {28'd0, operation}, 32'h6);
        chk("sub_res", aluresult, 32'hFFFFFFFE);
        chk("sub_zero", {31'd0, zero}, 32'd0);
        tick();
        drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("slt_res", aluresult, 32'd1);
        tick();
        drive(6'b000000, 6'b100111, 32'd0, 32'd0, 1'b0);
        chk("nor_res", aluresult, 32'hFFFFFFFF);
        tick();
        drive(6'b100011, 6'b000000, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("lw_wrap_res", aluresult, 32'd0);
        chk("lw_wrap_zero", {31'd0, zero}, 32'd1);
        chk("lw_memread", {31'd0, memread}, 32'd1);
        tick();
        drive(6'b000100, 6'b000000, 32'd1234, 32'd1234, 1'b0);
        chk("beq_eq", {27'd0, operation, zero, branch}, {27'd0, 4'b0110, 1'b1, 1'b1});
        tick();
        drive(6'b000100, 6'b000000, 32'd1234, 32'd1235, 1'b0);
        chk("beq_ne_zero", {31'd0, zero}, 32'd0);
        tick();

        // Halt then lw: masked controls, datapath still live
        drive(6'b111111, 6'b000000, 32'd0, 32'd0, 1'b0);
        tick();
        drive(6'b100011, 6'b000000, 32'd100, 32'd20, 1'b0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_mask", {29'd0, regwrite, memread, alusrc}, {29'd0, 3'b001});
        chk("halt_alu", aluresult, 32'd120);
        tick();
        drive(6'b100011, 6'b000000, 32'd1, 32'd2, 1'b1);
        tick();
        drive(6'b100011, 6'b000000, 32'd1, 32'd2, 1'b0);
        chk("reset_clears", {29'd0, halted, memread, regwrite}, {29'd0, 3'b011});
        tick();
        drive(6'b111111, 6'b000000, 32'd0, 32'd0, 1'b1);
        tick();
        drive(6'b000000, 6'b100000, 32'd1, 32'd1, 1'b0);
        chk("reset_beats_halt", {31'd0, halted}, 32'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  rop;
            logic [5:0]  rfn;
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rr;
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 7)];
            if (rop == 6'b111111 && $urandom_range(0, 3) != 0) rop = 6'b000000;
            rfn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 5)];
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            rr  = ($urandom_range(0, 9) == 0);
            drive(rop, rfn, ra, rb, rr);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
